fifo_mem_ctrl: RTL and testbench

Controller that sequences the dual-port FIFO memory (write port: FIFO_data_in/wr_ptr/write_enable; read port: rd_ptr/read_enable/FIFO_data_out).
- Turns push/pop requests into memory pointer and enable signals.
- Tracks occupancy and raises full/empty, almost-full/almost-empty and error flags.
- Sits between the producer/consumer logic and the memory; it carries no data.

---
 rtl/fifo_mem_ctrl_if.sv | 23 ++
 rtl/fifo_mem_ctrl.sv | 123 ++++++++++++
 tb/tb_fifo_mem_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_mem_ctrl_if.sv
// Handshake and memory-port bundle between producer/consumer logic, the
// FIFO controller (master) and the dual-port FIFO memory (slave).
interface fifo_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  write_enable;
    logic                  read_enable;
    logic                  data_valid;

    modport master (
        input  push, pop,
        output wr_ptr, rd_ptr, write_enable, read_enable, data_valid
    );

    modport slave (
        output push, pop,
        input  wr_ptr, rd_ptr, write_enable, read_enable, data_valid
    );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// Pointer/occupancy controller for a dual-port FIFO memory; carries no data.
// Define FIFO_ERR_STICKY_EN to hold overflow/underflow high until reset.
//
// state  | meaning
// INIT   | one cycle after reset release, latches thresholds, ignores push/pop
// EMPTY  | no entries stored
// NORMAL | between 1 and DEPTH-1 entries stored
// FULL   | DEPTH entries stored
module fifo_mem_ctrl #(
    parameter  int ADDR_WIDTH = 8,
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    fifo_mem_ctrl_if.master      bus,
    input  logic [CNT_WIDTH-1:0] almost_full_thr,
    input  logic [CNT_WIDTH-1:0] almost_empty_thr,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [CNT_WIDTH-1:0] fifo_count,
    output logic                 overflow,
    output logic                 underflow
);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(1 << ADDR_WIDTH);

    typedef enum logic [1:0] {INIT, EMPTY, NORMAL, FULL} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic                  data_valid_q;
    logic [CNT_WIDTH-1:0]  af_thr_q;
    logic [CNT_WIDTH-1:0]  ae_thr_q;
    logic [CNT_WIDTH-1:0]  af_thr_use;
    logic [CNT_WIDTH-1:0]  ae_thr_use;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  push_rej;
    logic                  pop_rej;
    logic                  in_init;

    assign in_init    = (state == INIT);
    assign fifo_empty = (state == INIT) || (state == EMPTY);
    assign fifo_full  = (state == FULL);

    assign push_ok  = bus.push & ~fifo_full & ~in_init;
    assign pop_ok   = bus.pop & ~fifo_empty;
    assign push_rej = bus.push & fifo_full;
    assign pop_rej  = bus.pop & fifo_empty & ~in_init;

    assign bus.write_enable = push_ok;
    assign bus.read_enable  = pop_ok;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.data_valid   = data_valid_q;

    // The INIT-cycle flag update must see the thresholds being latched, not the stale registers.
    assign af_thr_use = in_init ? almost_full_thr : af_thr_q;
    assign ae_thr_use = in_init ? almost_empty_thr : ae_thr_q;

    always_comb begin
        count_nxt = fifo_count;
        if (push_ok && !pop_ok) begin
            count_nxt = fifo_count + CNT_WIDTH'(1);
        end else if (pop_ok && !push_ok) begin
            count_nxt = fifo_count - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state        <= INIT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count   <= '0;
            data_valid_q <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            af_thr_q     <= '0;
            ae_thr_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_q + ADDR_WIDTH'(push_ok);
            rd_ptr_q     <= rd_ptr_q + ADDR_WIDTH'(pop_ok);
            fifo_count   <= count_nxt;
            data_valid_q <= pop_ok;
            almost_full  <= (count_nxt >= af_thr_use);
            almost_empty <= (count_nxt <= ae_thr_use);
`ifdef FIFO_ERR_STICKY_EN
            overflow     <= overflow | push_rej;
            underflow    <= underflow | pop_rej;
`else
            overflow     <= push_rej;
            underflow    <= pop_rej;
`endif
            case (state)
                INIT: begin
                    af_thr_q <= almost_full_thr;
                    ae_thr_q <= almost_empty_thr;
                    state    <= EMPTY;
                end
                EMPTY: begin
                    if (push_ok) state <= NORMAL;
                end
                NORMAL: begin
                    if (pop_ok && !push_ok && fifo_count == CNT_WIDTH'(1)) begin
                        state <= EMPTY;
                    end else if (push_ok && !pop_ok && fifo_count == DEPTH_C - CNT_WIDTH'(1)) begin
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (pop_ok) state <= NORMAL;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Self-checking bench for fifo_mem_ctrl: directed sequences plus random
// push/pop against an occupancy-based reference model, and an 8-bit wrap run.
module tb_fifo_mem_ctrl;
    localparam int AW_A    = 3;
    localparam int DEPTH_A = 1 << AW_A;
    localparam int AW_B    = 8;
    localparam int DEPTH_B = 1 << AW_B;

    logic clk;
    logic reset_L;
    logic [AW_A:0] t_af, t_ae;
    logic [AW_B:0] tb_af, tb_ae;

    logic          a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [AW_A:0] a_count;
    logic          b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [AW_B:0] b_count;

    fifo_mem_ctrl_if #(.ADDR_WIDTH(AW_A)) a_if ();
    fifo_mem_ctrl_if #(.ADDR_WIDTH(AW_B)) b_if ();

    fifo_mem_ctrl #(.ADDR_WIDTH(AW_A)) dut_a (
        .clk(clk), .reset_L(reset_L), .bus(a_if.master),
        .almost_full_thr(t_af), .almost_empty_thr(t_ae),
        .fifo_full(a_full), .fifo_empty(a_empty), .almost_full(a_af), .almost_empty(a_ae),
        .fifo_count(a_count), .overflow(a_ovf), .underflow(a_udf)
    );

    fifo_mem_ctrl #(.ADDR_WIDTH(AW_B)) dut_b (
        .clk(clk), .reset_L(reset_L), .bus(b_if.master),
        .almost_full_thr(tb_af), .almost_empty_thr(tb_ae),
        .fifo_full(b_full), .fifo_empty(b_empty), .almost_full(b_af), .almost_empty(b_ae),
        .fifo_count(b_count), .overflow(b_ovf), .underflow(b_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model for dut_a, in terms of occupancy
    bit m_init;
    int m_cnt, m_wr, m_rd, m_af_thr, m_ae_thr;
    bit m_dv, m_ovf, m_udf, m_af, m_ae;
    // reference model for dut_b
    int bm_cnt, bm_wr, bm_rd;
    bit b_wrapped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a_state();
        chk("wr_ptr", 32'(a_if.wr_ptr), 32'(m_wr));
        chk("rd_ptr", 32'(a_if.rd_ptr), 32'(m_rd));
        chk("fifo_count", 32'(a_count), 32'(m_cnt));
        chk("data_valid", 32'(a_if.data_valid), 32'(m_dv));
        chk("fifo_full", 32'(a_full), 32'(!m_init && m_cnt == DEPTH_A));
        chk("fifo_empty", 32'(a_empty), 32'(m_init || m_cnt == 0));
        chk("almost_full", 32'(a_af), 32'(m_af));
        chk("almost_empty", 32'(a_ae), 32'(m_ae));
        chk("overflow", 32'(a_ovf), 32'(m_ovf));
        chk("underflow", 32'(a_udf), 32'(m_udf));
    endtask

    // One clock of dut_a; entered and left just after a falling edge.
    task automatic cyc(input bit p, input bit q);
        bit full, empty, we, re, pr, qr;
        int af_use, ae_use;
        a_if.push = p;
        a_if.pop  = q;
        #1;
        full  = !m_init && m_cnt == DEPTH_A;
        empty = m_init || m_cnt == 0;
        we = p && !full && !m_init;
        re = q && !empty;
        pr = p && full;
        qr = q && empty && !m_init;
        chk("write_enable", 32'(a_if.write_enable), 32'(we));
        chk("read_enable", 32'(a_if.read_enable), 32'(re));
        af_use = m_init ? int'(t_af) : m_af_thr;
        ae_use = m_init ? int'(t_ae) : m_ae_thr;
        @(posedge clk);
        if (m_init) begin
            m_af_thr = int'(t_af);
            m_ae_thr = int'(t_ae);
        end
        m_init = 0;
        m_cnt  = m_cnt + int'(we) - int'(re);
        m_wr   = (m_wr + int'(we)) % DEPTH_A;
        m_rd   = (m_rd + int'(re)) % DEPTH_A;
        m_dv   = re;
        m_af   = m_cnt >= af_use;
        m_ae   = m_cnt <= ae_use;
`ifdef FIFO_ERR_STICKY_EN
        m_ovf = m_ovf | pr;
        m_udf = m_udf | qr;
`else
        m_ovf = pr;
        m_udf = qr;
`endif
        @(negedge clk);
        chk_a_state();
    endtask

    // Asynchronous reset with push/pop held high, then release on a falling edge.
    task automatic do_reset();
        a_if.push = 1'b1;
        a_if.pop  = 1'b1;
        reset_L   = 1'b0;
        #1;
        m_init = 1; m_cnt = 0; m_wr = 0; m_rd = 0;
        m_dv = 0; m_ovf = 0; m_udf = 0; m_af = 0; m_ae = 1;
        chk_a_state();
        chk("rst_write_enable", 32'(a_if.write_enable), 32'd0);
        chk("rst_read_enable", 32'(a_if.read_enable), 32'd0);
        bm_cnt = 0; bm_wr = 0; bm_rd = 0;
        @(posedge clk);
        @(negedge clk);
        a_if.push = 1'b0;
        a_if.pop  = 1'b0;
        reset_L   = 1'b1;
    endtask

    initial begin
        reset_L   = 1'b1;
        a_if.push = 1'b0; a_if.pop = 1'b0;
        b_if.push = 1'b0; b_if.pop = 1'b0;
        t_af  = 4'd6;   t_ae  = 4'd1;
        tb_af = 9'd200; tb_ae = 9'd1;
        #2;
        do_reset();

        // INIT cycle ignores push; thresholds are then changed to prove latching
        cyc(1, 0);
        t_af = 4'd2;
        t_ae = 4'd7;

        // fill, then one rejected push
        for (int i = 0; i < DEPTH_A; i++) cyc(1, 0);
        cyc(1, 0);
        chk("count_after_overflow", 32'(a_count), 32'd8);
        cyc(0, 0);

        // drain, then one rejected pop
        for (int i = 0; i < DEPTH_A; i++) cyc(0, 1);
        cyc(0, 1);
        cyc(0, 0);

        // simultaneous push+pop in NORMAL, FULL and EMPTY
        for (int i = 0; i < 4; i++) cyc(1, 0);
        cyc(1, 1);
        cyc(1, 1);
        chk("count_simul_normal", 32'(a_count), 32'd4);
        for (int i = 0; i < 4; i++) cyc(1, 0);
        cyc(1, 1);
        chk("count_simul_full", 32'(a_count), 32'd7);
        for (int i = 0; i < 7; i++) cyc(0, 1);
        cyc(1, 1);
        chk("count_simul_empty", 32'(a_count), 32'd1);

        // random traffic, first biased to fill then biased to drain
        for (int i = 0; i < 400; i++) begin
            bit p, q;
            if (i < 200) begin
                p = ($urandom_range(0, 3) != 0);
                q = ($urandom_range(0, 3) == 0);
            end else begin
                p = ($urandom_range(0, 3) == 0);
                q = ($urandom_range(0, 3) != 0);
            end
            cyc(p, q);
        end

        // 8-bit wrap stress on dut_b: 300 push/pop pairs
        b_wrapped = 0;
        for (int i = 0; i < 600; i++) begin
            bit bp, bq, bwe, bre;
            bp = (i % 2 == 0);
            bq = (i % 2 == 1);
            b_if.push = bp;
            b_if.pop  = bq;
            bwe = bp && bm_cnt < DEPTH_B;
            bre = bq && bm_cnt > 0;
            cyc(0, 0);
            if (bwe && bm_wr == DEPTH_B - 1) b_wrapped = 1;
            bm_cnt = bm_cnt + int'(bwe) - int'(bre);
            bm_wr  = (bm_wr + int'(bwe)) % DEPTH_B;
            bm_rd  = (bm_rd + int'(bre)) % DEPTH_B;
            chk("b_wr_ptr", 32'(b_if.wr_ptr), 32'(bm_wr));
            chk("b_rd_ptr", 32'(b_if.rd_ptr), 32'(bm_rd));
            chk("b_count", 32'(b_count), 32'(bm_cnt));
            chk("b_errors", 32'({b_ovf, b_udf}), 32'd0);
        end
        b_if.push = 1'b0;
        b_if.pop  = 1'b0;
        chk("b_pointer_wrapped", 32'(b_wrapped), 32'd1);

        // drain dut_a, fill to 5 and reset mid-fill
        for (int i = 0; i < 2 * DEPTH_A && m_cnt > 0; i++) cyc(0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0);
        chk("count_before_reset", 32'(a_count), 32'd5);
        t_af = 4'd7;
        t_ae = 4'd0;
        do_reset();

        // pop during INIT is not an error; the next one is
        cyc(0, 1);
        cyc(0, 1);
        cyc(1, 0);
        cyc(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
